// File: rtl/pcs_block_lock_ctrl.sv
// pcs_block_lock_ctrl: 64b/66b RX block lock; in i_sync_hdr/i_hdr_valid, out o_slip pulse, o_block_lock, saturating o_slip_count
module pcs_block_lock_ctrl #(
    parameter int SH_CNT_MAX  = 64,
    parameter int INVALID_MAX = 16,
    parameter int SLIP_WAIT   = 32,
    parameter int CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [1:0]       i_sync_hdr,
    input  logic             i_hdr_valid,
    output logic             o_slip,
    output logic             o_block_lock,
    output logic [CNT_W-1:0] o_slip_count
);
    localparam int SH_W  = $clog2(SH_CNT_MAX + 1);
    localparam int INV_W = $clog2(INVALID_MAX + 1);
    localparam int WT_W  = $clog2(SLIP_WAIT + 1);
    typedef enum logic [1:0] {TEST_SH, SLIP, SLIP_WT} state_t;
    state_t           state, state_nxt;
    logic [SH_W-1:0]  sh_cnt, sh_cnt_nxt, sh_nxt;
    logic [INV_W-1:0] inv_cnt, inv_cnt_nxt, inv_nxt;
    logic [WT_W-1:0]  wt_cnt, wt_cnt_nxt;
    logic [CNT_W-1:0] slip_count_nxt;
    logic             slip_nxt, lock_nxt, invalid;
    assign invalid = i_sync_hdr[1] ~^ i_sync_hdr[0];
    assign sh_nxt  = sh_cnt + 1'b1;
    assign inv_nxt = inv_cnt + INV_W'(invalid);
    always_comb begin
        state_nxt      = state;
        sh_cnt_nxt     = sh_cnt;
        inv_cnt_nxt    = inv_cnt;
        wt_cnt_nxt     = wt_cnt;
        slip_nxt       = 1'b0;
        lock_nxt       = o_block_lock;
        slip_count_nxt = o_slip_count;
        case (state)
            TEST_SH: if (i_hdr_valid) begin
                if (invalid && (inv_nxt == INV_W'(INVALID_MAX) || !o_block_lock)) begin
                    lock_nxt    = 1'b0;
                    slip_nxt    = 1'b1;
                    sh_cnt_nxt  = '0;
                    inv_cnt_nxt = '0;
                    state_nxt   = SLIP;
                end else if (sh_nxt == SH_W'(SH_CNT_MAX)) begin
                    sh_cnt_nxt  = '0;
                    inv_cnt_nxt = '0;
                    lock_nxt    = o_block_lock | (inv_nxt == '0);
                end else begin
                    sh_cnt_nxt  = sh_nxt;
                    inv_cnt_nxt = inv_nxt;
                end
            end
            SLIP: begin
                slip_count_nxt = &o_slip_count ? o_slip_count : o_slip_count + 1'b1;
                wt_cnt_nxt     = WT_W'(SLIP_WAIT - 1);
                state_nxt      = SLIP_WT;
            end
            SLIP_WT: begin
                wt_cnt_nxt = wt_cnt - 1'b1;
                state_nxt  = (wt_cnt <= WT_W'(1)) ? TEST_SH : SLIP_WT;
            end
            default: state_nxt = TEST_SH;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state        <= TEST_SH;
            sh_cnt       <= '0;
            inv_cnt      <= '0;
            wt_cnt       <= '0;
            o_slip       <= 1'b0;
            o_block_lock <= 1'b0;
            o_slip_count <= '0;
        end else begin
            state        <= state_nxt;
            sh_cnt       <= sh_cnt_nxt;
            inv_cnt      <= inv_cnt_nxt;
            wt_cnt       <= wt_cnt_nxt;
            o_slip       <= slip_nxt;
            o_block_lock <= lock_nxt;
            o_slip_count <= slip_count_nxt;
        end
    end
endmodule

// File: tb/tb_pcs_block_lock_ctrl.sv
// tb_pcs_block_lock_ctrl: random and directed stimulus checked against a cycle-budget reference model
module tb_pcs_block_lock_ctrl;
    localparam int SW = 32;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hv = 1'b0;
    logic [1:0]  hdr = 2'b00;
    logic        slip, lock, slip8, lock8;
    logic [15:0] cnt;
    logic [7:0]  cnt8;
    int          checks = 0;
    int          failures = 0;
    bit          chk_en = 1'b0;
    bit          m_lock, m_slip;
    int          m_cnt, m_sh, m_inv, m_blind;
    always #5 clk = ~clk;
    pcs_block_lock_ctrl dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_sync_hdr(hdr), .i_hdr_valid(hv),
        .o_slip(slip), .o_block_lock(lock), .o_slip_count(cnt)
    );
    pcs_block_lock_ctrl #(.CNT_W(8)) dut8 (
        .i_clk(clk), .i_reset_n(rst_n), .i_sync_hdr(hdr), .i_hdr_valid(hv),
        .o_slip(slip8), .o_block_lock(lock8), .o_slip_count(cnt8)
    );
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask
    // Headers are ignored for SW edges after the edge that decided a slip.
    function automatic void model_step();
        bit bad;
        if (!rst_n) begin
            m_lock = 0; m_slip = 0; m_cnt = 0; m_sh = 0; m_inv = 0; m_blind = 0;
            return;
        end
        if (m_slip) m_cnt++;
        m_slip = 0;
        bad = (hdr == 2'b00 || hdr == 2'b11);
        if (m_blind > 0) m_blind--;
        else if (hv) begin
            if (bad && (m_inv + 1 == 16 || !m_lock)) begin
                m_lock = 0; m_slip = 1; m_sh = 0; m_inv = 0; m_blind = SW;
            end else if (m_sh + 1 == 64) begin
                if (m_inv + int'(bad) == 0) m_lock = 1;
                m_sh = 0; m_inv = 0;
            end else begin
                m_sh++; m_inv += int'(bad);
            end
        end
    endfunction
    always @(negedge clk) if (chk_en) begin
        check("slip", {31'b0, slip}, {31'b0, m_slip});
        check("lock", {31'b0, lock}, {31'b0, m_lock});
        check("count16", {16'b0, cnt}, m_cnt > 65535 ? 32'd65535 : m_cnt);
        check("slip8", {31'b0, slip8}, {31'b0, m_slip});
        check("lock8", {31'b0, lock8}, {31'b0, m_lock});
        check("count8", {24'b0, cnt8}, m_cnt > 255 ? 32'd255 : m_cnt);
    end
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask
    task automatic hdr_in(input logic [1:0] h, input logic v);
        hdr = h;
        hv = v;
        tick();
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        hv = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask
    task automatic lock_up();
        do_reset();
        repeat (64) hdr_in(2'b01, 1'b1);
    endtask
    initial begin
        rst_n = 1'b0;
        tick();
        chk_en = 1'b1;
        repeat (2) tick();
        check("rst_slip", {31'b0, slip}, 0);
        check("rst_lock", {31'b0, lock}, 0);
        check("rst_cnt", {16'b0, cnt}, 0);
        rst_n = 1'b1;
        // T1
        repeat (63) hdr_in(2'b01, 1'b1);
        check("t1_lock63", {31'b0, lock}, 0);
        hdr_in(2'b01, 1'b1);
        check("t1_lock64", {31'b0, lock}, 1);
        check("t1_cnt", {16'b0, cnt}, 0);
        // T2
        do_reset();
        hdr_in(2'b11, 1'b1);
        check("t2_slip", {31'b0, slip}, 1);
        for (int i = 0; i < SW; i++) begin
            hdr_in(2'b11, 1'b1);
            check("t2_quiet", {31'b0, slip}, 0);
        end
        check("t2_cnt", {16'b0, cnt}, 1);
        hdr_in(2'b11, 1'b1);
        check("t2_reslip", {31'b0, slip}, 1);
        // T3
        lock_up();
        for (int i = 0; i < 64; i++)
            hdr_in((i % 4 == 1 && i < 60) ? 2'b00 : 2'b10, 1'b1);
        check("t3_hold_lock", {31'b0, lock}, 1);
        check("t3_hold_slip", {31'b0, slip}, 0);
        repeat (10) hdr_in(2'b01, 1'b1);
        repeat (15) hdr_in(2'b11, 1'b1);
        check("t3_lock15", {31'b0, lock}, 1);
        hdr_in(2'b11, 1'b1);
        check("t3_lock16", {31'b0, lock}, 0);
        check("t3_slip16", {31'b0, slip}, 1);
        // T4
        lock_up();
        for (int n = 0; n < 64; ) begin
            logic v;
            v = ($urandom_range(0, 2) != 0);
            hdr_in(v ? 2'b01 : 2'b11, v);
            if (v) n++;
        end
        check("t4_lock", {31'b0, lock}, 1);
        repeat (15) hdr_in(2'b00, 1'b1);
        repeat (49) hdr_in(2'b10, 1'b1);
        check("t4_window", {31'b0, lock}, 1);
        // Random traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 1499) == 0) do_reset();
            hdr_in(($urandom_range(0, 23) == 0) ? ($urandom_range(0, 1) ? 2'b00 : 2'b11)
                                               : ($urandom_range(0, 1) ? 2'b01 : 2'b10),
                   $urandom_range(0, 3) != 0);
        end
        // T5
        do_reset();
        repeat (256 * (SW + 1) + 200) hdr_in(2'b00, 1'b1);
        check("t5_cnt8_sat", {24'b0, cnt8}, 255);
        check("t5_cnt16_past", {31'b0, cnt > 16'd255}, 1);
        // T6
        do_reset();
        repeat (6) hdr_in(2'b11, 1'b1);
        rst_n = 1'b0;
        tick();
        check("t6_wait_slip", {31'b0, slip}, 0);
        check("t6_wait_lock", {31'b0, lock}, 0);
        check("t6_wait_cnt", {16'b0, cnt}, 0);
        lock_up();
        check("t6_relock", {31'b0, lock}, 1);
        rst_n = 1'b0;
        tick();
        check("t6_lock_rst", {31'b0, lock}, 0);
        rst_n = 1'b1;
        repeat (63) hdr_in(2'b01, 1'b1);
        check("t6_lock63", {31'b0, lock}, 0);
        hdr_in(2'b01, 1'b1);
        check("t6_lock64", {31'b0, lock}, 1);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
